// File: rtl/xsip_telemetry_pkg.sv
// Shared widths, record layout and full-buffer policy for the telemetry aggregator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package xsip_telemetry_pkg;

   localparam int TS_W   = 32;
   localparam int SCNT_W = 32;
   localparam int DCNT_W = 16;

   // What happens to a new record when the ring is full and nothing drains this cycle
   typedef enum logic {
      POL_BACKPRESSURE = 1'b0,
      POL_OVERWRITE    = 1'b1
   } pol_e;

   // Ring records are packed {ch, ts, data}, MSB to LSB
   function automatic int rec_width(input int ch_idx_w, input int ch_w);
      return ch_idx_w + TS_W + ch_w;
   endfunction

endpackage

// File: rtl/xsip_rr_arbiter.sv
// Round-robin arbiter: grants the lowest requesting index at or after the rotating pointer.
// Latency: combinational grant; pointer moves one cycle after an advance.
// Backpressure: pointer holds until advance, so a stalled grant stays on the same requester.
module xsip_rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req,
   input  logic             advance,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx
);

   logic [IDX_W-1:0] rr_ptr;
   logic [IDX_W-1:0] cand;
   logic             found;
   int               cand_i;

   // Scan cyclically from rr_ptr and take the first active request
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      cand_i    = 0;
      cand      = '0;
      for (int k = 0; k < N; k++) begin
         cand_i = int'(rr_ptr) + k;
         if (cand_i >= N) begin
            cand_i = cand_i - N;
         end
         cand = IDX_W'(cand_i);
         if (!found && req[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   // Rotate priority to just past the winner whenever its record is taken
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (advance) begin
         if (grant_idx == IDX_W'(N - 1)) begin
            rr_ptr <= '0;
         end else begin
            rr_ptr <= grant_idx + IDX_W'(1);
         end
      end
   end

endmodule

// File: rtl/xsip_telemetry_ring_aggregator.sv
// Telemetry aggregator: round-robin merge of NUM_CH producers into a DEPTH-entry record ring.
// Latency: 2 cycles from channel accept to out_valid when the block is empty.
// Backpressure: full ring stalls producers, or evicts the oldest entry in overwrite mode; drain never stalls.
module xsip_telemetry_ring_aggregator
   import xsip_telemetry_pkg::*;
#(
   parameter int NUM_CH   = 4,
   parameter int CH_W     = 256,
   parameter int DEPTH    = 16,
   parameter int CH_IDX_W = $clog2(NUM_CH),
   parameter int LVL_W    = $clog2(DEPTH + 2)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_CH-1:0]      ch_valid,
   output logic [NUM_CH-1:0]      ch_ready,
   input  logic [NUM_CH*CH_W-1:0] ch_data,
   input  logic                   cfg_enable,
   input  logic                   cfg_overwrite,
   input  logic                   cnt_clear,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [CH_W-1:0]        out_data,
   output logic [CH_IDX_W-1:0]    out_ch,
   output logic [TS_W-1:0]        out_ts,
   output logic [LVL_W-1:0]       fill_level,
   output logic [SCNT_W-1:0]      sample_count,
   output logic [DCNT_W-1:0]      drop_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int REC_W = rec_width(CH_IDX_W, CH_W);

   logic [REC_W-1:0]    ring [DEPTH];
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_ptr;
   logic [LVL_W-1:0]    count;
   logic [TS_W-1:0]     ts;
   logic [NUM_CH-1:0]   grant;
   logic [CH_IDX_W-1:0] grant_idx;
   logic [CH_W-1:0]     grant_data;
   logic [REC_W-1:0]    head_rec;
   pol_e                policy;
   logic                ring_full;
   logic                ring_empty;
   logic                pop;
   logic                can_accept;
   logic                accept;
   logic                overwrite;

   xsip_rr_arbiter #(
      .N     (NUM_CH),
      .IDX_W (CH_IDX_W)
   ) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (ch_valid),
      .advance   (accept),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   assign policy     = cfg_overwrite ? POL_OVERWRITE : POL_BACKPRESSURE;
   assign ring_full  = (count == LVL_W'(DEPTH));
   assign ring_empty = (count == '0);
   // Output register refills from the ring whenever it is empty or being consumed
   assign pop        = !ring_empty && (!out_valid || out_ready);
   // A same-cycle pop frees a slot, so a full ring still takes a push then
   assign can_accept = !ring_full || pop || (policy == POL_OVERWRITE);
   assign ch_ready   = (cfg_enable && can_accept) ? grant : '0;
   assign accept     = |(ch_valid & ch_ready);
   // Eviction only when truly full with no drain; the output register is never touched
   assign overwrite  = accept && ring_full && !pop;
   assign grant_data = ch_data[int'(grant_idx)*CH_W +: CH_W];
   assign head_rec   = ring[rd_ptr];
   assign fill_level = count + LVL_W'(out_valid);

   // Free-running capture timestamp
   always_ff @(posedge clk) begin
      if (rst) begin
         ts <= '0;
      end else begin
         ts <= ts + TS_W'(1);
      end
   end

   // Record storage: written at the accept edge, contents need no reset
   always_ff @(posedge clk) begin
      if (!rst && accept) begin
         ring[wr_ptr] <= {grant_idx, ts, grant_data};
      end
   end

   // Ring pointers and occupancy; overwrite advances the read side instead of growing count
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (accept) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop || overwrite) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (accept && !overwrite && !pop) begin
            count <= count + LVL_W'(1);
         end else if (pop && !accept) begin
            count <= count - LVL_W'(1);
         end
      end
   end

   // Head-of-line output register, held stable while stalled
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         out_ts    <= '0;
      end else if (pop) begin
         out_valid <= 1'b1;
         out_data  <= head_rec[CH_W-1:0];
         out_ts    <= head_rec[CH_W +: TS_W];
         out_ch    <= head_rec[REC_W-1 -: CH_IDX_W];
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Saturating statistics; clear beats a same-cycle increment
   always_ff @(posedge clk) begin
      if (rst || cnt_clear) begin
         sample_count <= '0;
         drop_count   <= '0;
      end else begin
         if (accept && (sample_count != '1)) begin
            sample_count <= sample_count + SCNT_W'(1);
         end
         if (overwrite && (drop_count != '1)) begin
            drop_count <= drop_count + DCNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_xsip_telemetry_ring_aggregator.sv
// Self-checking bench: queue-based reference model compared every cycle, plus directed literal checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_xsip_telemetry_ring_aggregator;

   localparam int NCH = 4;
   localparam int CHW = 256;
   localparam int DEP = 16;
   localparam int IW  = 2;
   localparam int LW  = 5;

   logic              clk = 1'b0;
   logic              rst;
   logic [NCH-1:0]    ch_valid;
   logic [NCH-1:0]    ch_ready;
   logic [NCH*CHW-1:0] ch_data;
   logic              cfg_enable;
   logic              cfg_overwrite;
   logic              cnt_clear;
   logic              out_valid;
   logic              out_ready;
   logic [CHW-1:0]    out_data;
   logic [IW-1:0]     out_ch;
   logic [31:0]       out_ts;
   logic [LW-1:0]     fill_level;
   logic [31:0]       sample_count;
   logic [15:0]       drop_count;

   always #5 clk = ~clk;

   xsip_telemetry_ring_aggregator #(
      .NUM_CH (NCH),
      .CH_W   (CHW),
      .DEPTH  (DEP)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .ch_valid      (ch_valid),
      .ch_ready      (ch_ready),
      .ch_data       (ch_data),
      .cfg_enable    (cfg_enable),
      .cfg_overwrite (cfg_overwrite),
      .cnt_clear     (cnt_clear),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .out_ch        (out_ch),
      .out_ts        (out_ts),
      .fill_level    (fill_level),
      .sample_count  (sample_count),
      .drop_count    (drop_count)
   );

   typedef struct {
      int unsigned    ch;
      logic [31:0]    ts;
      logic [CHW-1:0] data;
   } rec_t;

   // Reference model state: a plain queue for the ring plus one held output record
   rec_t           q[$];
   rec_t           m_out;
   bit             m_ov;
   int             m_rr;
   logic [31:0]    m_ts;
   longint         m_scnt;
   int             m_dcnt;
   bit             m_acc;
   int             m_g;
   logic [CHW-1:0] obs[$];
   logic [CHW-1:0] expq[$];
   int             total;
   int             bad;
   int             val;

   task automatic chk(input string name, input logic [CHW-1:0] act, input logic [CHW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_ov   = 1'b0;
      m_rr   = 0;
      m_ts   = '0;
      m_scnt = 0;
      m_dcnt = 0;
      m_out  = '{ch: 0, ts: '0, data: '0};
   endtask

   // One clock: compare DUT to model before the edge, then advance the model with the same inputs
   task automatic step();
      bit   pop;
      bit   can;
      bit   found;
      bit   full_before;
      logic [NCH-1:0] exp_rdy;
      rec_t r;
      #1;
      pop   = (q.size() > 0) && (!m_ov || out_ready);
      can   = (q.size() < DEP) || pop || cfg_overwrite;
      found = 1'b0;
      m_g   = 0;
      for (int k = 0; k < NCH; k++) begin
         if (!found && ch_valid[(m_rr + k) % NCH]) begin
            found = 1'b1;
            m_g   = (m_rr + k) % NCH;
         end
      end
      exp_rdy = (cfg_enable && can && found) ? (NCH'(1) << m_g) : '0;
      m_acc   = (exp_rdy != '0);
      chk("ch_ready", ch_ready, exp_rdy);
      chk("out_valid", out_valid, m_ov);
      if (m_ov) begin
         chk("out_data", out_data, m_out.data);
         chk("out_ch", out_ch, m_out.ch);
         chk("out_ts", out_ts, m_out.ts);
      end
      chk("fill_level", fill_level, q.size() + int'(m_ov));
      chk("sample_count", sample_count, m_scnt);
      chk("drop_count", drop_count, m_dcnt);
      if (m_ov && out_ready) obs.push_back(out_data);
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         full_before = (q.size() == DEP);
         if (pop) begin
            m_out = q.pop_front();
            m_ov  = 1'b1;
         end else if (out_ready) begin
            m_ov = 1'b0;
         end
         if (m_acc) begin
            if (full_before && !pop) begin
               r = q.pop_front();
               if (m_dcnt < 65535) m_dcnt++;
            end
            r.ch   = m_g;
            r.ts   = m_ts;
            r.data = ch_data[m_g*CHW +: CHW];
            q.push_back(r);
            m_rr = (m_g + 1) % NCH;
            if (m_scnt < 64'hFFFF_FFFF) m_scnt++;
         end
         if (cnt_clear) begin
            m_scnt = 0;
            m_dcnt = 0;
         end
         m_ts = m_ts + 32'd1;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      ch_valid = '0;
      step();
      rst = 1'b0;
   endtask

   // ch0 producer offering 1..limit, advancing on the model's accept
   task automatic feed0(input int cycles, input int limit);
      for (int c = 0; c < cycles; c++) begin
         ch_valid[0]      = (val <= limit);
         ch_data[0 +: CHW] = CHW'(val);
         step();
         if (m_acc && m_g == 0) val++;
      end
      ch_valid[0] = 1'b0;
   endtask

   task automatic cmp_seq(input string name);
      chk({name, "_len"}, obs.size(), expq.size());
      for (int i = 0; i < expq.size() && i < obs.size(); i++) chk(name, obs[i], expq[i]);
   endtask

   initial begin
      rst = 1'b1; ch_valid = '0; ch_data = '0; cfg_enable = 1'b1; cfg_overwrite = 1'b0;
      cnt_clear = 1'b0; out_ready = 1'b1; total = 0; bad = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      model_reset();
      step();
      rst = 1'b0;
      #1;
      chk("rst_out_data", out_data, 0);
      chk("rst_out_ch", out_ch, 0);
      chk("rst_out_ts", out_ts, 0);
      chk("rst_fill", fill_level, 0);

      // Single record latency and timestamp
      repeat (10) step();
      ch_valid[2] = 1'b1;
      ch_data[2*CHW +: CHW] = CHW'(8'hA5);
      #1 chk("t1_ready", ch_ready, 4'b0100);
      step();
      ch_valid = '0;
      step();
      #1;
      chk("t1_valid", out_valid, 1);
      chk("t1_ch", out_ch, 2);
      chk("t1_ts", out_ts, 10);
      chk("t1_data", out_data, 8'hA5);
      chk("t1_scnt", sample_count, 1);

      // All channels busy: strict rotation
      do_reset();
      ch_valid = '1;
      for (int c = 0; c < 20; c++) begin
         ch_data = {32{$urandom}};
         #1 chk("t2_order", ch_ready, NCH'(1) << (c % 4));
         step();
         chk("t2_fill_le2", (fill_level <= 2), 1);
      end
      ch_valid = '0;
      #1;
      chk("t2_scnt", sample_count, 20);
      chk("t2_drop", drop_count, 0);

      // Backpressure when full, lossless drain
      do_reset();
      cfg_overwrite = 1'b0; out_ready = 1'b0; val = 1;
      feed0(25, 20);
      #1;
      chk("t3_accepted", val - 1, 17);
      chk("t3_fill", fill_level, 17);
      chk("t3_drop", drop_count, 0);
      ch_valid[0] = 1'b1;
      #1 chk("t3_ready_low", ch_ready, 0);
      obs.delete(); out_ready = 1'b1;
      feed0(30, 20);
      expq.delete();
      for (int i = 1; i <= 20; i++) expq.push_back(CHW'(i));
      cmp_seq("t3_seq");

      // Overwrite-oldest keeps newest and never disturbs the output register
      do_reset();
      cfg_overwrite = 1'b1; out_ready = 1'b0; val = 1;
      for (int c = 0; c < 22; c++) begin
         feed0(1, 20);
         if (m_ov) chk("t4_hold", out_data, 1);
      end
      #1;
      chk("t4_accepted", val - 1, 20);
      chk("t4_drop", drop_count, 3);
      chk("t4_fill", fill_level, 17);
      obs.delete(); out_ready = 1'b1;
      repeat (25) step();
      expq.delete();
      expq.push_back(CHW'(1));
      for (int i = 5; i <= 20; i++) expq.push_back(CHW'(i));
      cmp_seq("t4_seq");

      // Full ring with simultaneous push and pop in backpressure mode
      do_reset();
      cfg_overwrite = 1'b0; out_ready = 1'b0; val = 1;
      feed0(20, 17);
      ch_valid[1] = 1'b1;
      ch_data[CHW +: CHW] = CHW'(8'h77);
      out_ready = 1'b1;
      #1 chk("t5_ready", ch_ready, 4'b0010);
      step();
      ch_valid = '0; out_ready = 1'b0;
      #1;
      chk("t5_fill", fill_level, 17);
      chk("t5_drop", drop_count, 0);
      chk("t5_scnt", sample_count, 18);

      // Counter clear beats increment; reset flushes buffered records
      do_reset();
      cfg_overwrite = 1'b0; out_ready = 1'b0; val = 1;
      feed0(3, 100);
      cnt_clear = 1'b1;
      feed0(1, 100);
      cnt_clear = 1'b0;
      #1 chk("t6_clear", sample_count, 0);
      for (int c = 0; c < 20 && (q.size() + int'(m_ov)) < 10; c++) feed0(1, 100);
      #1 chk("t6_fill10", fill_level, 10);
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      chk("t6_rst_valid", out_valid, 0);
      chk("t6_rst_fill", fill_level, 0);
      out_ready = 1'b1;
      ch_valid[0] = 1'b1;
      ch_data[0 +: CHW] = CHW'(8'h33);
      step();
      ch_valid = '0;
      step();
      #1;
      chk("t6_valid", out_valid, 1);
      chk("t6_ts0", out_ts, 0);

      // Randomised traffic with shifting drain pressure and policy
      do_reset();
      for (int ph = 0; ph < 8; ph++) begin
         int rdy_pct;
         cfg_overwrite = ph[0];
         rdy_pct = (ph % 3 == 0) ? 10 : ((ph % 3 == 1) ? 50 : 90);
         for (int c = 0; c < 500; c++) begin
            ch_valid   = NCH'($urandom);
            ch_data    = {32{$urandom}};
            out_ready  = ($urandom_range(0, 99) < rdy_pct);
            cfg_enable = ($urandom_range(0, 15) != 0);
            cnt_clear  = ($urandom_range(0, 199) == 0);
            rst        = ($urandom_range(0, 1499) == 0);
            step();
         end
      end
      rst = 1'b0; ch_valid = '0; cnt_clear = 1'b0; cfg_enable = 1'b1; out_ready = 1'b1;
      repeat (25) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
